// File: rtl/ld_sched.sv
// Round-robin scheduler sharing one load-enabled register bank among NREQ requesters.
// Each grant produces a single load cycle followed by one settle cycle.
module ld_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] raddr,
  input  logic [NREQ*DW-1:0] rdata,
  input  logic               freeze,
  output logic [NREQ-1:0]    ack,
  output logic [NREG-1:0]    ld,
  output logic [DW-1:0]      ldd,
  output logic               err,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

  state_t        state;
  logic [PW-1:0] rr;
  logic [PW-1:0] w_s;
  logic [PW-1:0] win;
  logic          found;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          in_range;

  // First asserted request scanning upward from rr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign win_addr = raddr[win*AW +: AW];
  assign win_data = rdata[win*DW +: DW];
  assign in_range = 32'(win_addr) < 32'(NREG);

  // Outputs are loaded at the arbitration edge so the strobe lands in the
  // LOAD cycle; ldd doubles as the data staging register through GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr    <= '0;
      w_s   <= '0;
      ack   <= '0;
      ld    <= '0;
      ldd   <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !freeze) begin
            state <= LOAD;
            w_s   <= win;
            ack   <= NREQ'(1) << win;
            ld    <= in_range ? (NREG'(1) << win_addr) : '0;
            err   <= !in_range;
            ldd   <= win_data;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= GAP;
          rr    <= (w_s == PW'(NREQ - 1)) ? '0 : w_s + 1'b1;
          ack   <= '0;
          ld    <= '0;
          err   <= 1'b0;
          busy  <= 1'b1;
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          ld    <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
